// File: rtl/conv2d_stream_engine.sv
`default_nettype none
// =============================================================================
// Module   : conv2d_stream_engine
// Brief    : Streaming KxK "valid" 2-D convolution with line buffers, loadable
//            kernel, arithmetic shift, optional ReLU and output saturation.
// Revision : 1.0
// =============================================================================
module conv2d_stream_engine #(
   parameter int IMG_W  = 8,
   parameter int IMG_H  = 8,
   parameter int KSIZE  = 3,
   parameter int DATA_W = 8,
   parameter int COEF_W = 8,
   parameter int OUT_W  = 16,
   localparam int c_NCOEF = KSIZE*KSIZE,
   localparam int c_CA_W  = $clog2(KSIZE*KSIZE)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_start,
   input  logic                i_cfg_relu,
   input  logic [4:0]          i_cfg_shift,
   input  logic                i_coef_we,
   input  logic [c_CA_W-1:0]   i_coef_addr,
   input  logic [COEF_W-1:0]   i_coef_wdata,
   input  logic                i_in_valid,
   output logic                o_in_ready,
   input  logic [DATA_W-1:0]   i_in_data,
   output logic                o_out_valid,
   input  logic                i_out_ready,
   output logic [OUT_W-1:0]    o_out_data,
   output logic                o_out_last,
   output logic                o_busy,
   output logic                o_done
);

   localparam int c_ACC_W  = DATA_W + COEF_W + 1 + $clog2(KSIZE*KSIZE);
   localparam int c_PROD_W = DATA_W + COEF_W + 1;
   localparam int c_COL_W  = $clog2(IMG_W);
   localparam int c_ROW_W  = $clog2(IMG_H);

   localparam logic [1:0] c_ST_IDLE  = 2'd0;
   localparam logic [1:0] c_ST_RUN   = 2'd1;
   localparam logic [1:0] c_ST_FLUSH = 2'd2;
   localparam logic [1:0] c_ST_DONE  = 2'd3;

   logic [1:0]                 r_state;
   logic [1:0]                 w_state_nxt;

   logic signed [COEF_W-1:0]   r_coef [c_NCOEF];
   logic [DATA_W-1:0]          r_lb   [KSIZE-1][IMG_W];
   logic [DATA_W-1:0]          r_win  [KSIZE][KSIZE];
   logic [c_COL_W-1:0]         r_col;
   logic [c_ROW_W-1:0]         r_row;
   logic                       r_relu;
   logic [4:0]                 r_shift;

   logic                       r_s1_valid;
   logic                       r_s1_last;
   logic signed [c_PROD_W-1:0] r_prod [c_NCOEF];
   logic                       r_out_valid;
   logic                       r_out_last;
   logic [OUT_W-1:0]           r_out_data;

   logic [DATA_W-1:0]          w_col     [KSIZE];
   logic [DATA_W-1:0]          w_win_nxt [KSIZE][KSIZE];
   logic signed [c_PROD_W-1:0] w_prod    [c_NCOEF];
   logic signed [c_ACC_W-1:0]  w_acc;
   logic signed [c_ACC_W-1:0]  w_shifted;
   logic signed [c_ACC_W-1:0]  w_relu;
   logic [OUT_W-1:0]           w_res;

   logic                       w_stall;
   logic                       w_accept;
   logic                       w_win_done;
   logic                       w_last_px;
   logic                       w_start_ok;

   assign w_stall    = r_out_valid & ~i_out_ready;
   assign w_accept   = i_in_valid & o_in_ready;
   assign w_start_ok = (r_state == c_ST_IDLE) & i_start;
   assign w_win_done = w_accept & (r_row >= c_ROW_W'(KSIZE-1)) & (r_col >= c_COL_W'(KSIZE-1));
   assign w_last_px  = w_accept & (r_row == c_ROW_W'(IMG_H-1)) & (r_col == c_COL_W'(IMG_W-1));

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= c_ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_ST_IDLE:  if (i_start) w_state_nxt = c_ST_RUN;
         c_ST_RUN:   if (w_last_px) w_state_nxt = c_ST_FLUSH;
         c_ST_FLUSH: if (r_out_valid & i_out_ready & r_out_last) w_state_nxt = c_ST_DONE;
         c_ST_DONE:  w_state_nxt = c_ST_IDLE;
         default:    w_state_nxt = c_ST_IDLE;
      endcase
   end

   always_comb begin
      o_in_ready = 1'b0;
      o_busy     = 1'b0;
      o_done     = 1'b0;
      case (r_state)
         c_ST_RUN: begin
            o_in_ready = ~w_stall;
            o_busy     = 1'b1;
         end
         c_ST_FLUSH: o_busy = 1'b1;
         c_ST_DONE:  o_done = 1'b1;
         default: ;
      endcase
   end

   // ------------------------------------------------ coefficients / config
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j < c_NCOEF; j++) r_coef[j] <= '0;
      end else if ((r_state == c_ST_IDLE) && i_coef_we) begin
         for (int j = 0; j < c_NCOEF; j++)
            if (i_coef_addr == c_CA_W'(j)) r_coef[j] <= i_coef_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_col   <= '0;
         r_row   <= '0;
         r_relu  <= 1'b0;
         r_shift <= '0;
      end else if (w_start_ok) begin
         r_col   <= '0;
         r_row   <= '0;
         r_relu  <= i_cfg_relu;
         r_shift <= i_cfg_shift;
      end else if (w_accept) begin
         if (r_col == c_COL_W'(IMG_W-1)) begin
            r_col <= '0;
            r_row <= (r_row == c_ROW_W'(IMG_H-1)) ? '0 : r_row + 1'b1;
         end else begin
            r_col <= r_col + 1'b1;
         end
      end
   end

   // ------------------------------------------- line buffers and window
   // Line buffer j holds row (r-1-j) at each column; the new column vector is
   // built top-to-bottom from the oldest buffer down to the incoming pixel.
   always_comb begin
      for (int i = 0; i < KSIZE-1; i++) w_col[i] = r_lb[KSIZE-2-i][r_col];
      w_col[KSIZE-1] = i_in_data;
      for (int i = 0; i < KSIZE; i++) begin
         for (int k = 0; k < KSIZE-1; k++) w_win_nxt[i][k] = r_win[i][k+1];
         w_win_nxt[i][KSIZE-1] = w_col[i];
      end
      for (int i = 0; i < KSIZE; i++)
         for (int k = 0; k < KSIZE; k++)
            w_prod[i*KSIZE+k] = c_PROD_W'($signed({1'b0, w_win_nxt[i][k]}))
                              * c_PROD_W'(r_coef[i*KSIZE+k]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < KSIZE; i++)
            for (int k = 0; k < KSIZE; k++) r_win[i][k] <= '0;
         for (int j = 0; j < KSIZE-1; j++)
            for (int c = 0; c < IMG_W; c++) r_lb[j][c] <= '0;
      end else if (w_accept) begin
         for (int i = 0; i < KSIZE; i++)
            for (int k = 0; k < KSIZE; k++) r_win[i][k] <= w_win_nxt[i][k];
         r_lb[0][r_col] <= i_in_data;
         for (int j = 1; j < KSIZE-1; j++) r_lb[j][r_col] <= r_lb[j-1][r_col];
      end
   end

   // ------------------------------------------------ sum / shift / clamp
   always_comb begin
      w_acc = '0;
      for (int j = 0; j < c_NCOEF; j++) w_acc = w_acc + c_ACC_W'(r_prod[j]);
      w_shifted = w_acc >>> r_shift;
      w_relu    = (r_relu && w_shifted[c_ACC_W-1]) ? '0 : w_shifted;
   end

   if (c_ACC_W > OUT_W) begin : g_clamp
      localparam logic signed [c_ACC_W-1:0] c_MAXV =
         {{(c_ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
      localparam logic signed [c_ACC_W-1:0] c_MINV =
         {{(c_ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
      always_comb begin
         if (w_relu > c_MAXV)      w_res = c_MAXV[OUT_W-1:0];
         else if (w_relu < c_MINV) w_res = c_MINV[OUT_W-1:0];
         else                      w_res = w_relu[OUT_W-1:0];
      end
   end else begin : g_wide
      assign w_res = OUT_W'(w_relu);
   end

   // A stall freezes both pipe stages so the presented result stays put.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid  <= 1'b0;
         r_s1_last   <= 1'b0;
         for (int j = 0; j < c_NCOEF; j++) r_prod[j] <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_data  <= '0;
      end else if (!w_stall) begin
         r_s1_valid <= w_win_done;
         if (w_win_done) begin
            r_s1_last <= w_last_px;
            for (int j = 0; j < c_NCOEF; j++) r_prod[j] <= w_prod[j];
         end
         r_out_valid <= r_s1_valid;
         r_out_last  <= r_s1_valid & r_s1_last;
         if (r_s1_valid) r_out_data <= w_res;
      end
   end

   assign o_out_valid = r_out_valid;
   assign o_out_last  = r_out_last;
   assign o_out_data  = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_conv2d_stream_engine.sv
`default_nettype none
// Bench for conv2d_stream_engine: tabulated constant-result frames, randomized
// frames against a direct-convolution model, and reset/coefficient corner cases.
module tb_conv2d_stream_engine;
   localparam int W = 8, H = 8, K = 3, NC = K*K, NR = (W-K+1)*(H-K+1);

   logic        clk, rst_n;
   logic        i_start, i_cfg_relu, i_coef_we, i_in_valid, i_out_ready;
   logic [4:0]  i_cfg_shift;
   logic [3:0]  i_coef_addr;
   logic [7:0]  i_coef_wdata, i_in_data;
   logic        o_in_ready, o_out_valid, o_out_last, o_busy, o_done;
   logic [15:0] o_out_data;

   conv2d_stream_engine #(.IMG_W(W), .IMG_H(H), .KSIZE(K), .DATA_W(8), .COEF_W(8), .OUT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_cfg_relu(i_cfg_relu),
      .i_cfg_shift(i_cfg_shift), .i_coef_we(i_coef_we), .i_coef_addr(i_coef_addr),
      .i_coef_wdata(i_coef_wdata), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
      .i_in_data(i_in_data), .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
      .o_out_data(o_out_data), .o_out_last(o_out_last), .o_busy(o_busy), .o_done(o_done));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   int pix [H][W];
   int coef [NC];
   int exp_q [$];

   typedef struct { int pmode; int kmode; bit relu; int shift; int expv; } vec_t;
   vec_t tbl [7];

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   function automatic void set_kernel(input int km);
      for (int j = 0; j < NC; j++)
         case (km)
            0: coef[j] = 1;
            1: coef[j] = (j < 3) ? -1 : ((j >= 6) ? 1 : 0);
            2: coef[j] = (j < 3) ? 1 : ((j >= 6) ? -1 : 0);
            3: coef[j] = 127;
            4: coef[j] = -128;
            5: coef[j] = 0;
            default: coef[j] = int'($urandom_range(0, 255)) - 128;
         endcase
   endfunction

   function automatic void set_pix(input int pm);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            case (pm)
               0: pix[r][c] = 1;
               1: pix[r][c] = r;
               2: pix[r][c] = 255;
               default: pix[r][c] = int'($urandom_range(0, 255));
            endcase
   endfunction

   // Direct valid-mode convolution: sum, floor shift, ReLU, saturate.
   function automatic void model(input bit relu, input int shift);
      exp_q.delete();
      for (int r = 0; r <= H-K; r++)
         for (int c = 0; c <= W-K; c++) begin
            int acc;
            acc = 0;
            for (int i = 0; i < K; i++)
               for (int j = 0; j < K; j++) acc += pix[r+i][c+j] * coef[i*K+j];
            acc = acc >>> shift;
            if (relu && acc < 0) acc = 0;
            if (acc > 32767) acc = 32767;
            if (acc < -32768) acc = -32768;
            exp_q.push_back(acc);
         end
   endfunction

   function automatic void const_exp(input int v);
      exp_q.delete();
      for (int n = 0; n < NR; n++) exp_q.push_back(v);
   endfunction

   task automatic load_coefs();
      for (int j = 0; j < NC; j++) begin
         @(negedge clk);
         i_coef_we = 1'b1; i_coef_addr = 4'(j); i_coef_wdata = coef[j][7:0];
      end
      @(negedge clk);
      i_coef_we = 1'b0;
   endtask

   task automatic run_frame(input bit relu, input int shift, input int gap, input int rdy,
                            input int wr_at, input string tag);
      int idx, nres, cyc, acc_cyc, ov_cyc;
      bit prev_stall, got_done;
      logic [15:0] prev_data;
      @(negedge clk);
      i_start = 1'b1; i_cfg_relu = relu; i_cfg_shift = shift[4:0];
      @(negedge clk);
      i_start = 1'b0;
      #1;
      check({tag, " busy_on_start"}, o_busy, 1);
      idx = 0; nres = 0; cyc = 0; acc_cyc = -1; ov_cyc = -1;
      prev_stall = 1'b0; got_done = 1'b0; prev_data = '0;
      while (cyc < 4000 && !got_done) begin
         i_in_valid   = (idx < W*H) && ($urandom_range(0, 99) >= gap);
         i_in_data    = (idx < W*H) ? pix[idx/W][idx%W][7:0] : 8'h00;
         i_out_ready  = ($urandom_range(0, 99) < rdy);
         i_coef_we    = (cyc == wr_at);
         i_start      = (cyc == wr_at);
         i_coef_addr  = 4'd4;
         i_coef_wdata = 8'd50;
         i_cfg_relu   = 1'($urandom);
         i_cfg_shift  = 5'($urandom);
         #1;
         if (prev_stall) begin
            check({tag, " stall_valid"}, o_out_valid, 1);
            check({tag, " stall_data"}, o_out_data, prev_data);
         end
         if (o_done) begin
            got_done = 1'b1;
         end else begin
            if (i_in_valid && o_in_ready) begin
               if (idx == (K-1)*W + K-1) acc_cyc = cyc;
               idx++;
            end
            if (o_out_valid && ov_cyc < 0) ov_cyc = cyc;
            if (o_out_valid && i_out_ready) begin
               if (nres < exp_q.size())
                  check($sformatf("%s result[%0d]", tag, nres), longint'($signed(o_out_data)), exp_q[nres]);
               else
                  check({tag, " extra_result"}, nres, exp_q.size() - 1);
               check($sformatf("%s last[%0d]", tag, nres), o_out_last, (nres == NR-1) ? 1 : 0);
               nres++;
            end
            prev_stall = o_out_valid && !i_out_ready;
            prev_data  = o_out_data;
            @(negedge clk);
            cyc++;
         end
      end
      i_in_valid = 1'b0; i_start = 1'b0; i_coef_we = 1'b0;
      check({tag, " done_seen"}, got_done, 1);
      check({tag, " result_count"}, nres, NR);
      if (gap == 0 && rdy == 100 && acc_cyc >= 0)
         check({tag, " latency"}, ov_cyc - acc_cyc, 2);
      @(negedge clk);
      #1;
      check({tag, " done_single"}, o_done, 0);
      check({tag, " busy_after"}, o_busy, 0);
   endtask

   initial begin
      int n, cyc;
      rst_n = 1'b0; i_start = 0; i_cfg_relu = 0; i_cfg_shift = 0; i_coef_we = 0;
      i_coef_addr = 0; i_coef_wdata = 0; i_in_valid = 0; i_in_data = 0; i_out_ready = 0;
      tbl[0] = '{0, 0, 1'b0, 0, 9};
      tbl[1] = '{1, 1, 1'b0, 0, 6};
      tbl[2] = '{1, 2, 1'b0, 0, -6};
      tbl[3] = '{1, 2, 1'b1, 0, 0};
      tbl[4] = '{2, 3, 1'b0, 0, 32767};
      tbl[5] = '{2, 3, 1'b0, 8, 1138};
      tbl[6] = '{2, 4, 1'b0, 0, -32768};

      #1;
      check("rst in_ready", o_in_ready, 0);
      check("rst out_valid", o_out_valid, 0);
      check("rst out_last", o_out_last, 0);
      check("rst out_data", o_out_data, 0);
      check("rst busy", o_busy, 0);
      check("rst done", o_done, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      for (int t = 0; t < 7; t++) begin
         set_pix(tbl[t].pmode);
         set_kernel(tbl[t].kmode);
         load_coefs();
         const_exp(tbl[t].expv);
         run_frame(tbl[t].relu, tbl[t].shift, 0, 100, -1, $sformatf("vec%0d", t));
      end

      set_pix(1); set_kernel(1); load_coefs(); const_exp(6);
      run_frame(1'b0, 0, 40, 50, -1, "backpressure");

      for (int f = 0; f < 3; f++) begin
         bit relu;
         int sh;
         relu = 1'($urandom);
         sh = int'($urandom_range(0, 12));
         set_pix(3); set_kernel(9); load_coefs(); model(relu, sh);
         run_frame(relu, sh, 30, 50, -1, $sformatf("rand%0d", f));
      end

      // Abort a frame with reset after 20 accepted pixels.
      set_pix(0); set_kernel(0); load_coefs();
      @(negedge clk); i_start = 1'b1; i_cfg_relu = 0; i_cfg_shift = 0;
      @(negedge clk); i_start = 1'b0;
      n = 0; cyc = 0;
      while (n < 20 && cyc < 200) begin
         i_in_valid = 1'b1; i_in_data = 8'd1; i_out_ready = 1'b1;
         #1;
         if (o_in_ready) n++;
         @(negedge clk);
         cyc++;
      end
      i_in_valid = 1'b0;
      check("abort accepted", n, 20);
      #2 rst_n = 1'b0;
      #1;
      check("abort in_ready", o_in_ready, 0);
      check("abort out_valid", o_out_valid, 0);
      check("abort out_last", o_out_last, 0);
      check("abort out_data", o_out_data, 0);
      check("abort busy", o_busy, 0);
      check("abort done", o_done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      set_kernel(5); model(1'b0, 0);
      run_frame(1'b0, 0, 0, 100, -1, "post_reset_zero_coef");
      set_kernel(0); load_coefs(); model(1'b0, 0);
      run_frame(1'b0, 0, 0, 100, -1, "post_reset_reload");

      // Coefficient write and start while running are both ignored.
      set_pix(1); set_kernel(1); load_coefs(); const_exp(6);
      run_frame(1'b0, 0, 0, 100, 10, "coef_we_run");
      run_frame(1'b0, 0, 0, 100, -1, "coef_we_next");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
